// File: rtl/uart_frame_assembler_if.sv
// Byte-in / word-out bundle for uart_frame_assembler: UART receive strobe, word FIFO handshake, frame status.
interface uart_frame_assembler_if #(
  parameter int WORD_BYTES = 2
);
  logic [7:0]              RX_DATA;
  logic                    RX_DONE;
  logic [8*WORD_BYTES-1:0] WORD_OUT;
  logic                    WORD_VALID;
  logic                    WORD_READY;
  logic                    FRAME_DONE;
  logic                    FRAME_ERR;
  logic                    OVF_STICKY;

  // WORD_OUT transfers on every cycle where WORD_VALID && WORD_READY; VALID never depends on READY,
  // and RX_DONE is a one-cycle strobe with no back-pressure.
  modport master (
    output RX_DATA, RX_DONE, WORD_READY,
    input  WORD_OUT, WORD_VALID, FRAME_DONE, FRAME_ERR, OVF_STICKY
  );

  modport slave (
    input  RX_DATA, RX_DONE, WORD_READY,
    output WORD_OUT, WORD_VALID, FRAME_DONE, FRAME_ERR, OVF_STICKY
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// Assembles SYNC/LEN/payload[/CHK] UART frames into little-endian words behind a FWFT word FIFO.
// Define UART_FRAME_CHECKSUM_EN to expect and verify a trailing mod-256 checksum byte.
module uart_frame_assembler #(
  parameter int         WORD_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                 CLK100MHZ,
  input  logic                 RESET,
  uart_frame_assembler_if.slave bus,
  output logic [1:0]           state_dbg
);
  localparam int WW = 8 * WORD_BYTES;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);

`ifdef UART_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {S_SYNC = 2'd0, S_LEN = 2'd1, S_PAYLOAD = 2'd2, S_CHK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_SYNC = 2'd0, S_LEN = 2'd1, S_PAYLOAD = 2'd2} state_t;
`endif

  state_t          state, state_next;
  logic [7:0]      len_q;
  logic [7:0]      word_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [WW-1:0]   word_acc, word_next;
  logic            frame_ovf, ovf_sticky;
  logic            last_byte, last_word;
  logic            push, pop, full, blocked, push_ok, drop;
  logic            frame_done, frame_err;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]      chk;
`endif

  logic [WW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [WW-1:0]   last_out;

  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_word = (word_cnt == len_q - 8'd1);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = (count != '0) && bus.WORD_READY;
  // A simultaneous pop frees the slot, so a push into a full FIFO is only lost when nothing leaves.
  assign blocked   = full && !pop;
  assign push_ok   = push && !blocked;
  assign drop      = push && blocked;

  always_comb begin
    word_next = word_acc;
    word_next[{byte_cnt, 3'b000} +: 8] = bus.RX_DATA;
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) state <= S_SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (bus.RX_DONE) begin
      unique case (state)
        S_SYNC: if (bus.RX_DATA == SYNC_BYTE) state_next = S_LEN;
        S_LEN: begin
          if (bus.RX_DATA == 8'd0) begin
            frame_err  = 1'b1;
            state_next = S_SYNC;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (last_byte) begin
            push = 1'b1;
            if (last_word) begin
`ifdef UART_FRAME_CHECKSUM_EN
              state_next = S_CHK;
`else
              state_next = S_SYNC;
              frame_err  = frame_ovf || blocked;
              frame_done = !(frame_ovf || blocked);
`endif
            end
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        S_CHK: begin
          state_next = S_SYNC;
          if (bus.RX_DATA == chk && !frame_ovf) frame_done = 1'b1;
          else                                  frame_err  = 1'b1;
        end
`endif
        default: state_next = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      len_q      <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word_acc   <= '0;
      frame_ovf  <= 1'b0;
      ovf_sticky <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      if (drop) ovf_sticky <= 1'b1;
      if (bus.RX_DONE) begin
        if (state == S_LEN) begin
          len_q     <= bus.RX_DATA;
          word_cnt  <= '0;
          byte_cnt  <= '0;
          word_acc  <= '0;
          frame_ovf <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
          chk       <= bus.RX_DATA;
`endif
        end else if (state == S_PAYLOAD) begin
          word_acc <= word_next;
`ifdef UART_FRAME_CHECKSUM_EN
          chk      <= chk + bus.RX_DATA;
`endif
          if (drop) frame_ovf <= 1'b1;
          if (last_byte) begin
            byte_cnt <= '0;
            word_cnt <= word_cnt + 8'd1;
          end else begin
            byte_cnt <= byte_cnt + BW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) mem[wr_ptr] <= word_next;
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_out <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_out <= mem[rd_ptr];
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // When empty, WORD_OUT keeps showing the most recently consumed word.
  assign bus.WORD_OUT   = (count != '0) ? mem[rd_ptr] : last_out;
  assign bus.WORD_VALID = (count != '0);
  assign bus.FRAME_DONE = frame_done;
  assign bus.FRAME_ERR  = frame_err;
  assign bus.OVF_STICKY = ovf_sticky;
  assign state_dbg      = state;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: directed frame table, reset/overflow sequences, random frames vs byte-queue model.
module tb_uart_frame_assembler;
  localparam int         WB    = 2;
  localparam int         W     = 8 * WB;
  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [1:0] ST_SYNC = 2'd0, ST_LEN = 2'd1, ST_PAYLOAD = 2'd2;
  localparam int         NV = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  logic       rand_ready;

  uart_frame_assembler_if #(.WORD_BYTES(WB)) bus();

  uart_frame_assembler #(.WORD_BYTES(WB), .SYNC_BYTE(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: bytes of the current frame, expected FIFO contents
  logic [7:0]   fb[$];
  logic [W-1:0] exp_q[$];
  logic         ovf_m = 1'b0, bad_m = 1'b0;
  logic         m_done, m_err, m_push, m_drop, m_pop;
  logic [W-1:0] m_word;
  int           npay, pidx, m_sum;

  always @(negedge clk) begin
    if (rst) begin
      fb.delete();
      exp_q.delete();
      ovf_m = 1'b0;
      bad_m = 1'b0;
    end else begin
      m_done = 1'b0; m_err = 1'b0; m_push = 1'b0; m_drop = 1'b0;
      m_pop  = (exp_q.size() != 0) && bus.WORD_READY;
      if (bus.RX_DONE) begin
        if (fb.size() == 0) begin
          if (bus.RX_DATA == SYNC) fb.push_back(bus.RX_DATA);
        end else begin
          fb.push_back(bus.RX_DATA);
          if (fb.size() == 2) begin
            if (bus.RX_DATA == 8'd0) begin
              m_err = 1'b1;
              fb.delete();
            end else begin
              bad_m = 1'b0;
            end
          end else begin
            npay = int'(fb[1]) * WB;
            pidx = fb.size() - 2;
            if (pidx <= npay && (pidx % WB) == 0) begin
              m_word = '0;
              for (int k = 0; k < WB; k++) m_word[8*k +: 8] = fb[fb.size() - WB + k];
              m_push = 1'b1;
              m_drop = (exp_q.size() == DEPTH) && !m_pop;
              if (m_drop) bad_m = 1'b1;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            if (pidx == npay + 1) begin
              m_sum = 0;
              for (int k = 1; k < fb.size() - 1; k++) m_sum += int'(fb[k]);
              if (bus.RX_DATA == 8'(m_sum) && !bad_m) m_done = 1'b1;
              else                                    m_err  = 1'b1;
              fb.delete();
            end
`else
            if (pidx == npay) begin
              if (bad_m) m_err = 1'b1;
              else       m_done = 1'b1;
              fb.delete();
            end
`endif
          end
        end
      end
      check("m_word_valid", bus.WORD_VALID, exp_q.size() != 0);
      if (exp_q.size() != 0) check("m_word_out", bus.WORD_OUT, exp_q[0]);
      check("m_frame_done", bus.FRAME_DONE, m_done);
      check("m_frame_err", bus.FRAME_ERR, m_err);
      check("m_ovf_sticky", bus.OVF_STICKY, ovf_m);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push && !m_drop) exp_q.push_back(m_word);
      if (m_drop) ovf_m = 1'b1;
    end
  end

  // ---------------- observer: consumed words and pulse counts
  logic [W-1:0] got_q[$];
  int           done_cnt, err_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.WORD_VALID && bus.WORD_READY) got_q.push_back(bus.WORD_OUT);
      if (bus.FRAME_DONE) done_cnt++;
      if (bus.FRAME_ERR)  err_cnt++;
    end
  end

  task automatic clear_obs();
    got_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // ---------------- driver tasks (all inputs change 1 time unit after the rising edge)
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.WORD_READY = ($urandom_range(0, 2) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.RX_DATA = b;
    bus.RX_DONE = 1'b1;
    step();
    bus.RX_DONE = 1'b0;
    repeat (gap) step();
  endtask

  // ---------------- directed frame table; bytes packed first byte in [7:0], words word0 in [15:0]
  typedef struct {
    int          nb;
    logic [63:0] b;
    logic        has_chk;
    logic [7:0]  chk;
    int          nw;
    logic [63:0] w;
    int          res_csum;   // 0 none, 1 FRAME_DONE, 2 FRAME_ERR
    int          res_plain;
  } vec_t;

  vec_t tv [NV];

  task automatic send_vec(input int i);
    for (int j = 0; j < tv[i].nb; j++) send_byte(tv[i].b[8*j +: 8], 1);
`ifdef UART_FRAME_CHECKSUM_EN
    if (tv[i].has_chk) send_byte(tv[i].chk, 1);
`endif
  endtask

  task automatic rand_frame();
    int         len;
    logic [7:0] b;
    logic [7:0] sum;
    if ($urandom_range(0, 3) == 0) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      send_byte(b, $urandom_range(0, 2));
    end
    len = $urandom_range(0, 6);
    send_byte(SYNC, $urandom_range(0, 2));
    send_byte(8'(len), $urandom_range(0, 2));
    sum = 8'(len);
    for (int k = 0; k < len * WB; k++) begin
      b = 8'($urandom_range(0, 255));
      sum = sum + b;
      send_byte(b, $urandom_range(0, 2));
    end
`ifdef UART_FRAME_CHECKSUM_EN
    if (len != 0) begin
      if ($urandom_range(0, 3) == 0) sum = sum ^ 8'(1 << $urandom_range(0, 7));
      send_byte(sum, $urandom_range(0, 2));
    end
`else
    sum = sum;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int             res;
    logic [W-1:0]   exp_d [5];

    bus.RX_DATA    = 8'h00;
    bus.RX_DONE    = 1'b0;
    bus.WORD_READY = 1'b0;
    rand_ready     = 1'b0;
    rst            = 1'b1;

    // LEN+payload checksum of the 2-word frame is 8'h16; C6 and 00 are both wrong.
    tv[0] = '{6, 64'h0000_5678_1234_02A5, 1'b1, 8'h16, 2, 64'h5678_1234, 1, 1};
    tv[1] = '{6, 64'h0000_5678_1234_02A5, 1'b1, 8'h00, 2, 64'h5678_1234, 2, 1};
    tv[2] = '{6, 64'h0000_5678_1234_02A5, 1'b1, 8'hC6, 2, 64'h5678_1234, 2, 1};
    tv[3] = '{4, 64'h0000_0000_00A5_FF00, 1'b0, 8'h00, 0, 64'h0,         2, 2};
    tv[4] = '{4, 64'h0000_0000_ABCD_01A5, 1'b1, 8'h79, 1, 64'hABCD,      1, 1};
    tv[5] = '{5, 64'h0000_00FF_FF01_A511, 1'b1, 8'hFF, 1, 64'hFFFF,      1, 1};

    step();
    step();
    check("rst_word_valid", bus.WORD_VALID, 1'b0);
    check("rst_word_out", bus.WORD_OUT, '0);
    check("rst_frame_done", bus.FRAME_DONE, 1'b0);
    check("rst_frame_err", bus.FRAME_ERR, 1'b0);
    check("rst_ovf", bus.OVF_STICKY, 1'b0);
    check("rst_state", state_dbg, ST_SYNC);
    rst = 1'b0;
    step();

    // table-driven frames with READY held high
    bus.WORD_READY = 1'b1;
    for (int i = 0; i < NV; i++) begin
      clear_obs();
      send_vec(i);
      repeat (6) step();
      check($sformatf("tv%0d_nwords", i), got_q.size(), tv[i].nw);
      for (int j = 0; j < tv[i].nw; j++)
        if (j < got_q.size()) check($sformatf("tv%0d_word%0d", i, j), got_q[j], tv[i].w[W*j +: W]);
`ifdef UART_FRAME_CHECKSUM_EN
      res = tv[i].res_csum;
`else
      res = tv[i].res_plain;
`endif
      check($sformatf("tv%0d_done", i), done_cnt, (res == 1) ? 1 : 0);
      check($sformatf("tv%0d_err", i), err_cnt, (res == 2) ? 1 : 0);
      check($sformatf("tv%0d_state", i), state_dbg, ST_SYNC);
    end
    check("hold_valid", bus.WORD_VALID, 1'b0);
    check("hold_word_out", bus.WORD_OUT, 16'hFFFF);

    // reset in the middle of a frame abandons it
    clear_obs();
    send_byte(SYNC, 1);
    check("abort_state_len", state_dbg, ST_LEN);
    send_byte(8'h02, 1);
    check("abort_state_payload", state_dbg, ST_PAYLOAD);
    send_byte(8'h34, 1);
    rst = 1'b1;
    step();
    check("abort_rst_state", state_dbg, ST_SYNC);
    check("abort_rst_valid", bus.WORD_VALID, 1'b0);
    rst = 1'b0;
    step();
    send_byte(8'h12, 1);
    send_byte(8'h78, 1);
    send_byte(8'h56, 1);
    check("abort_tail_state", state_dbg, ST_SYNC);
    send_vec(0);
    repeat (6) step();
    check("abort_nwords", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("abort_word0", got_q[0], 16'h1234);
      check("abort_word1", got_q[1], 16'h5678);
    end
    check("abort_done", done_cnt, 1);
    check("abort_err", err_cnt, 0);

    // LEN=5 with READY low: four words held, fifth dropped
    rst = 1'b1; step(); rst = 1'b0; step();
    bus.WORD_READY = 1'b0;
    clear_obs();
    check("ovf_pre", bus.OVF_STICKY, 1'b0);
    send_byte(SYNC, 1);
    send_byte(8'h05, 1);
    for (int k = 1; k <= 10; k++) send_byte(8'(k), 1);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'h3C, 1);
`endif
    repeat (3) step();
    check("ovf_sticky", bus.OVF_STICKY, 1'b1);
    check("ovf_err", err_cnt, 1);
    check("ovf_done", done_cnt, 0);
    check("ovf_held_valid", bus.WORD_VALID, 1'b1);
    check("ovf_head", bus.WORD_OUT, 16'h0201);
    bus.WORD_READY = 1'b1;
    repeat (8) step();
    check("ovf_nwords", got_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) check($sformatf("ovf_word%0d", k), got_q[k], {8'(2*k + 2), 8'(2*k + 1)});
    check("ovf_drained", bus.WORD_VALID, 1'b0);

    // push and pop in the same cycle while full: accepted, no overflow
    rst = 1'b1; step(); rst = 1'b0; step();
    bus.WORD_READY = 1'b0;
    clear_obs();
    send_byte(SYNC, 1);
    send_byte(8'h04, 1);
    for (int k = 0; k < 8; k++) send_byte(8'(8'h11 + k), 1);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'hA8, 1);
`endif
    send_byte(SYNC, 1);
    send_byte(8'h01, 1);
    send_byte(8'h21, 1);
    bus.RX_DATA    = 8'h22;
    bus.RX_DONE    = 1'b1;
    bus.WORD_READY = 1'b1;
    step();
    bus.RX_DONE    = 1'b0;
    bus.WORD_READY = 1'b0;
    step();
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(8'h44, 1);
`endif
    repeat (2) step();
    check("full_pp_ovf", bus.OVF_STICKY, 1'b0);
    check("full_pp_err", err_cnt, 0);
    check("full_pp_done", done_cnt, 2);
    check("full_pp_one_popped", got_q.size(), 1);
    bus.WORD_READY = 1'b1;
    repeat (8) step();
    exp_d[0] = 16'h1211; exp_d[1] = 16'h1413; exp_d[2] = 16'h1615; exp_d[3] = 16'h1817; exp_d[4] = 16'h2221;
    check("full_pp_nwords", got_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < got_q.size()) check($sformatf("full_pp_word%0d", k), got_q[k], exp_d[k]);

    // random frames, random READY, checked cycle by cycle against the model
    rst = 1'b1; step(); rst = 1'b0; step();
    rand_ready = 1'b1;
    repeat (120) rand_frame();
    rand_ready = 1'b0;
    bus.WORD_READY = 1'b1;
    repeat (20) step();
    check("rand_model_drained", exp_q.size(), 0);
    check("rand_dut_drained", bus.WORD_VALID, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
